cpu_fetch_responder: RTL

- Memory-side responder for the instruction-fetch bus driven by the fetch unit's instruction cache. It answers request/address with read data and a ready pulse, after a programmable number of wait states.
- Backed by a synchronous on-chip word RAM.
- Has a secondary load port so a boot/debug loader can write program words into the same RAM.
- Sits between the CPU fetch bus and the boot ROM/RAM region.

---
 rtl/cpu_fetch_responder.sv | 129 ++++++++++++
 1 files changed

// File: rtl/cpu_fetch_responder.sv
// Instruction-fetch bus responder backed by a synchronous word RAM, with a
// boot/debug loader port that writes into the same RAM between fetches.
module cpu_fetch_responder #(
    parameter logic [31:0] BASE        = 32'h0000_0000,
    parameter int          WORDS       = 4096,
    parameter int          WAIT_STATES = 1,
    parameter logic [31:0] ERROR_DATA  = 32'h0000_0013
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_bus_request,
    output logic        o_bus_ready,
    input  logic [31:0] i_bus_address,
    output logic [31:0] o_bus_rdata,
    input  logic        i_load_we,
    input  logic [31:0] i_load_address,
    input  logic [31:0] i_load_wdata,
    output logic        o_load_busy,
    output logic        o_fetch_error
);
    localparam int          AW        = $clog2(WORDS);
    localparam logic [31:0] WORDS_32  = 32'(WORDS);
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_STATES);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT,
        RESPOND,
        RELEASE
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [3:0]    wait_count;
    logic [AW-1:0] read_index;
    logic [31:0]   mem [WORDS];

    logic [31:0]   fetch_word;
    logic [31:0]   load_word;
    logic          fetch_in_range;
    logic          load_in_range;
    logic          load_take;
    logic          fetch_issue;
    logic          rdata_capture;

    // Offsets wrap modulo 2^32, so addresses below BASE land far out of range.
    assign fetch_word     = (i_bus_address - BASE) >> 2;
    assign load_word      = (i_load_address - BASE) >> 2;
    assign fetch_in_range = (fetch_word < WORDS_32);
    assign load_in_range  = (load_word < WORDS_32);

    assign o_bus_ready = (state == RESPOND);
    assign o_load_busy = (state == READ) || (state == WAIT) || (state == RESPOND);
    assign load_take   = i_load_we && !o_load_busy && load_in_range;

    // A loader write arriving in IDLE wins; the request is simply re-sampled next cycle.
    assign fetch_issue = (state == IDLE) && i_bus_request && !i_load_we;

    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        state_next    = state;
        rdata_capture = 1'b0;
        case (state)
            IDLE: begin
                if (fetch_issue) begin
                    state_next = fetch_in_range ? READ : RESPOND;
                end
            end
            READ: begin
                if (WAIT_STATES == 0) begin
                    state_next    = RESPOND;
                    rdata_capture = 1'b1;
                end else begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (wait_count == 4'd1) begin
                    state_next    = RESPOND;
                    rdata_capture = 1'b1;
                end
            end
            RESPOND: state_next = RELEASE;
            RELEASE: begin
                if (!i_bus_request) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state         <= IDLE;
            wait_count    <= '0;
            read_index    <= '0;
            o_bus_rdata   <= '0;
            o_fetch_error <= 1'b0;
        end else begin
            state <= state_next;
            if (fetch_issue) begin
                if (fetch_in_range) begin
                    read_index <= fetch_word[AW-1:0];
                end else begin
                    o_bus_rdata   <= ERROR_DATA;
                    o_fetch_error <= 1'b1;
                end
            end
            if (state == READ) begin
                wait_count <= WAIT_INIT;
            end else if (state == WAIT) begin
                wait_count <= wait_count - 4'd1;
            end
            if (rdata_capture) begin
                o_bus_rdata <= mem[read_index];
            end
        end
    end

    // NOTE: the RAM array is deliberately not reset so it maps onto block memory.
    always_ff @(posedge i_clock) begin
        if (load_take) begin
            mem[load_word[AW-1:0]] <= i_load_wdata;
        end
    end

endmodule
